// File: rtl/drc_pkg.sv
// Shared DRC definitions: capture state machine state codes, RX mode codes
// and the RX scheduler state encoding, plus small decode helpers.
package drc_pkg;

  typedef enum logic [2:0] {
    CS_SLEEP       = 3'd0,
    CS_IDLE        = 3'd1,
    CS_ALIGN       = 3'd2,
    CS_CAPTURE     = 3'd3,
    CS_ERR_CORRECT = 3'd4
  } cs_state_e;

  typedef enum logic [1:0] {
    MODE_SLEEP       = 2'd0,
    MODE_SINGLE_SHOT = 2'd1,
    MODE_STREAM      = 2'd2,
    MODE_RSVD        = 2'd3
  } rx_mode_e;

  typedef enum logic [1:0] {
    SCH_OFF    = 2'd0,
    SCH_SINGLE = 2'd1,
    SCH_STREAM = 2'd2,
    SCH_SKIP   = 2'd3
  } sch_state_e;

  // True while the capture state machine is inside a frame (ALIGN/CAPTURE/ERR_CORRECT).
  function automatic logic cs_in_frame(input logic [2:0] st);
    return (st == CS_ALIGN) || (st == CS_CAPTURE) || (st == CS_ERR_CORRECT);
  endfunction

  // Reserved mode code is driven to the state machine as sleep.
  function automatic logic [1:0] mode_sanitize(input logic [1:0] mode);
    return (mode == MODE_RSVD) ? MODE_SLEEP : mode;
  endfunction

endpackage

// File: rtl/drc_rx_scheduler_if.sv
// Link between the RX scheduler (master) and the capture state machine (slave).
interface drc_rx_scheduler_if;

  logic       cam_rx_en;
  logic [1:0] cam_rx_mode;
  logic       cam_rx_start;
  logic       cam_rx_start_qed;
  logic [2:0] cam_rx_state;
  logic       cam_frm_done;
  logic       cam_frm_err;

  modport master (
    output cam_rx_en,
    output cam_rx_mode,
    output cam_rx_start,
    input  cam_rx_start_qed,
    input  cam_rx_state,
    input  cam_frm_done,
    input  cam_frm_err
  );

  modport slave (
    input  cam_rx_en,
    input  cam_rx_mode,
    input  cam_rx_start,
    output cam_rx_start_qed,
    output cam_rx_state,
    output cam_frm_done,
    output cam_frm_err
  );

endinterface

// File: rtl/drc_start_queue.sv
// Saturating counter of pending single-shot start requests with a sticky
// overflow flag. A push and a pop in the same cycle cancel out; a push while
// full is dropped and flagged; a pop while empty is ignored.
module drc_start_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             clr,
  input  logic             ovf_clr,
  output logic [CNT_W-1:0] cnt_nxt,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             ovf_r;
  logic             full_s;
  logic             ovf_set_s;

  assign full_s = (cnt_r == DEPTH_C);

  // Next count and overflow detection; clear dominates everything.
  always_comb begin
    cnt_nxt_s = cnt_r;
    ovf_set_s = 1'b0;
    if (clr) begin
      cnt_nxt_s = {CNT_W{1'b0}};
    end else begin
      ovf_set_s = push & full_s;
      if (push && !pop) begin
        if (!full_s) begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end else if (pop && !push) begin
        if (cnt_r != {CNT_W{1'b0}}) begin
          cnt_nxt_s = cnt_r - CNT_W'(1);
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end else begin
        cnt_nxt_s = cnt_r;
      end
    end
  end

  // Pending count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      cnt_r <= cnt_nxt_s;
    end
  end

  // Sticky overflow flag; software clear wins over a new overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_r <= 1'b0;
    end else if (ovf_clr) begin
      ovf_r <= 1'b0;
    end else if (ovf_set_s) begin
      ovf_r <= 1'b1;
    end else begin
      ovf_r <= ovf_r;
    end
  end

  assign cnt_nxt = cnt_nxt_s;
  assign cnt     = cnt_r;
  assign ovf     = ovf_r;

endmodule

// File: rtl/drc_rx_scheduler.sv
// DVP RX scheduler: turns CSR mode/start commands into enable/mode/start for
// the capture state machine, decimates stream frames, watchdogs stuck
// captures and aggregates frame/error status and the interrupt.
module drc_rx_scheduler
  import drc_pkg::*;
#(
  parameter int START_Q_DEPTH = 4,
  parameter int Q_CNT_W       = $clog2(START_Q_DEPTH + 1),
  parameter int SKIP_W        = 4,
  parameter int WDT_W         = 24,
  parameter int STS_CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 csr_rx_en,
  input  logic [1:0]           csr_rx_mode,
  input  logic                 csr_start_wr,
  input  logic [SKIP_W-1:0]    csr_frm_skip,
  input  logic [WDT_W-1:0]     csr_wdt_limit,
  input  logic [2:0]           csr_irq_msk,
  input  logic                 csr_sts_clr,
  input  logic                 dvp_vsync_pls,
  drc_rx_scheduler_if.master   cam,
  output logic [Q_CNT_W-1:0]   sts_pend_cnt,
  output logic                 sts_q_ovf,
  output logic                 sts_wdt_to,
  output logic [STS_CNT_W-1:0] sts_frm_cnt,
  output logic [STS_CNT_W-1:0] sts_err_cnt,
  output logic                 irq
);

  sch_state_e           state_r;
  sch_state_e           state_nxt_s;
  logic [SKIP_W-1:0]    skip_cnt_r;
  logic [SKIP_W-1:0]    skip_nxt_s;
  logic                 start_nxt_s;
  logic                 start_r;
  logic                 rx_en_r;
  logic [1:0]           rx_mode_r;
  logic [1:0]           mode_prev_r;
  logic                 mode_chg_s;
  logic                 single_req_s;
  logic                 stream_req_s;
  logic [Q_CNT_W-1:0]   pend_nxt_s;
  logic [WDT_W-1:0]     wdt_cnt_r;
  logic                 wdt_act_s;
  logic                 wdt_evt_s;
  logic                 wdt_to_r;
  logic [STS_CNT_W-1:0] frm_cnt_r;
  logic [STS_CNT_W-1:0] err_cnt_r;
  logic                 irq_r;

  assign single_req_s = csr_rx_en && (csr_rx_mode == MODE_SINGLE_SHOT);
  assign stream_req_s = csr_rx_en && (csr_rx_mode == MODE_STREAM);
  assign mode_chg_s   = (csr_rx_mode != mode_prev_r);

  drc_start_queue #(
    .DEPTH (START_Q_DEPTH),
    .CNT_W (Q_CNT_W)
  ) u_start_queue (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (csr_start_wr),
    .pop     (cam.cam_rx_start_qed),
    .clr     (!single_req_s),
    .ovf_clr (csr_sts_clr),
    .cnt_nxt (pend_nxt_s),
    .cnt     (sts_pend_cnt),
    .ovf     (sts_q_ovf)
  );

  // Watchdog fires once the in-frame cycle count reaches a non-zero limit;
  // a frame completing or erroring in the same cycle is progress, not a hang.
  assign wdt_act_s = cs_in_frame(cam.cam_rx_state);
  assign wdt_evt_s = wdt_act_s && !cam.cam_frm_done && !cam.cam_frm_err &&
                     (csr_wdt_limit != {WDT_W{1'b0}}) && (wdt_cnt_r == csr_wdt_limit);

  // Count cycles spent inside a frame; restart on any frame event or timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdt_cnt_r <= {WDT_W{1'b0}};
    end else if (!wdt_act_s || cam.cam_frm_done || cam.cam_frm_err || wdt_evt_s) begin
      wdt_cnt_r <= {WDT_W{1'b0}};
    end else begin
      wdt_cnt_r <= wdt_cnt_r + WDT_W'(1);
    end
  end

  // Scheduler next state, skip counter and start request for the next cycle.
  always_comb begin
    state_nxt_s = state_r;
    skip_nxt_s  = skip_cnt_r;
    start_nxt_s = 1'b0;
    case (state_r)
      SCH_OFF: begin
        if (single_req_s) begin
          state_nxt_s = SCH_SINGLE;
        end else if (stream_req_s) begin
          state_nxt_s = SCH_STREAM;
        end else begin
          state_nxt_s = SCH_OFF;
        end
      end
      SCH_SINGLE: begin
        state_nxt_s = SCH_SINGLE;
      end
      SCH_STREAM: begin
        if (cam.cam_frm_done && (csr_frm_skip != {SKIP_W{1'b0}})) begin
          state_nxt_s = SCH_SKIP;
          skip_nxt_s  = csr_frm_skip;
        end else begin
          state_nxt_s = SCH_STREAM;
        end
      end
      SCH_SKIP: begin
        if (dvp_vsync_pls) begin
          if (skip_cnt_r <= SKIP_W'(1)) begin
            state_nxt_s = SCH_STREAM;
            skip_nxt_s  = {SKIP_W{1'b0}};
          end else begin
            skip_nxt_s  = skip_cnt_r - SKIP_W'(1);
          end
        end else begin
          state_nxt_s = SCH_SKIP;
        end
      end
      default: begin
        state_nxt_s = SCH_OFF;
      end
    endcase

    // Disable, a mode change or a watchdog timeout parks the scheduler; the
    // state machine finishes any frame already in flight on its own.
    if (wdt_evt_s || ((state_r != SCH_OFF) && (!csr_rx_en || mode_chg_s))) begin
      state_nxt_s = SCH_OFF;
      skip_nxt_s  = {SKIP_W{1'b0}};
    end else begin
      state_nxt_s = state_nxt_s;
    end

    case (state_nxt_s)
      SCH_SINGLE: start_nxt_s = (pend_nxt_s != {Q_CNT_W{1'b0}});
      SCH_STREAM: start_nxt_s = 1'b1;
      default:    start_nxt_s = 1'b0;
    endcase
  end

  // Scheduler state, skip counter and registered control outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= SCH_OFF;
      skip_cnt_r  <= {SKIP_W{1'b0}};
      start_r     <= 1'b0;
      rx_en_r     <= 1'b0;
      rx_mode_r   <= 2'd0;
      mode_prev_r <= 2'd0;
    end else begin
      state_r     <= state_nxt_s;
      skip_cnt_r  <= skip_nxt_s;
      start_r     <= start_nxt_s;
      rx_en_r     <= csr_rx_en;
      rx_mode_r   <= mode_sanitize(csr_rx_mode);
      mode_prev_r <= csr_rx_mode;
    end
  end

  // Status counters and sticky watchdog flag; software clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frm_cnt_r <= {STS_CNT_W{1'b0}};
      err_cnt_r <= {STS_CNT_W{1'b0}};
      wdt_to_r  <= 1'b0;
    end else if (csr_sts_clr) begin
      frm_cnt_r <= {STS_CNT_W{1'b0}};
      err_cnt_r <= {STS_CNT_W{1'b0}};
      wdt_to_r  <= 1'b0;
    end else begin
      frm_cnt_r <= cam.cam_frm_done ? (frm_cnt_r + STS_CNT_W'(1)) : frm_cnt_r;
      err_cnt_r <= cam.cam_frm_err  ? (err_cnt_r + STS_CNT_W'(1)) : err_cnt_r;
      wdt_to_r  <= wdt_to_r | wdt_evt_s;
    end
  end

  // One-cycle interrupt pulse from the masked event sources.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_r <= 1'b0;
    end else begin
      irq_r <= |({wdt_evt_s, cam.cam_frm_err, cam.cam_frm_done} & csr_irq_msk);
    end
  end

  assign cam.cam_rx_en    = rx_en_r;
  assign cam.cam_rx_mode  = rx_mode_r;
  assign cam.cam_rx_start = start_r;
  assign sts_wdt_to       = wdt_to_r;
  assign sts_frm_cnt      = frm_cnt_r;
  assign sts_err_cnt      = err_cnt_r;
  assign irq              = irq_r;

endmodule

// File: tb/tb_drc_rx_scheduler.sv
// Self-checking bench for drc_rx_scheduler: vector table for the start queue,
// directed sequences for stream skip, watchdog, counter wrap and reset, and a
// randomized single-shot phase against a behavioural model.
module tb_drc_rx_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        csr_rx_en;
  logic [1:0]  csr_rx_mode;
  logic        csr_start_wr;
  logic [3:0]  csr_frm_skip;
  logic [23:0] csr_wdt_limit;
  logic [2:0]  csr_irq_msk;
  logic        csr_sts_clr;
  logic        dvp_vsync_pls;
  logic [2:0]  sts_pend_cnt;
  logic        sts_q_ovf;
  logic        sts_wdt_to;
  logic [15:0] sts_frm_cnt;
  logic [15:0] sts_err_cnt;
  logic        irq;

  drc_rx_scheduler_if cam_if ();

  drc_rx_scheduler dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .csr_rx_en     (csr_rx_en),
    .csr_rx_mode   (csr_rx_mode),
    .csr_start_wr  (csr_start_wr),
    .csr_frm_skip  (csr_frm_skip),
    .csr_wdt_limit (csr_wdt_limit),
    .csr_irq_msk   (csr_irq_msk),
    .csr_sts_clr   (csr_sts_clr),
    .dvp_vsync_pls (dvp_vsync_pls),
    .cam           (cam_if),
    .sts_pend_cnt  (sts_pend_cnt),
    .sts_q_ovf     (sts_q_ovf),
    .sts_wdt_to    (sts_wdt_to),
    .sts_frm_cnt   (sts_frm_cnt),
    .sts_err_cnt   (sts_err_cnt),
    .irq           (irq)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic       wr;
    logic       qed;
    logic [2:0] pend;
    logic       ovf;
    logic       start;
  } qvec_t;

  qvec_t qv [0:16];

  // behavioural model state for the randomized phase
  int          m_pend;
  bit          m_ovf;
  logic [15:0] m_frm;
  logic [15:0] m_err;
  logic        m_irq;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; csr_rx_en = 1'b0; csr_rx_mode = 2'd0; csr_start_wr = 1'b0;
    csr_frm_skip = 4'd0; csr_wdt_limit = 24'd0; csr_irq_msk = 3'd0;
    csr_sts_clr = 1'b0; dvp_vsync_pls = 1'b0;
    cam_if.cam_rx_start_qed = 1'b0; cam_if.cam_rx_state = 3'd0;
    cam_if.cam_frm_done = 1'b0; cam_if.cam_frm_err = 1'b0;

    // {wr, qed, pend after, ovf after, start after}
    qv[0]  = '{1'b0, 1'b1, 3'd0, 1'b0, 1'b0};
    qv[1]  = '{1'b1, 1'b0, 3'd1, 1'b0, 1'b1};
    qv[2]  = '{1'b1, 1'b0, 3'd2, 1'b0, 1'b1};
    qv[3]  = '{1'b1, 1'b0, 3'd3, 1'b0, 1'b1};
    qv[4]  = '{1'b0, 1'b1, 3'd2, 1'b0, 1'b1};
    qv[5]  = '{1'b0, 1'b1, 3'd1, 1'b0, 1'b1};
    qv[6]  = '{1'b0, 1'b1, 3'd0, 1'b0, 1'b0};
    qv[7]  = '{1'b1, 1'b0, 3'd1, 1'b0, 1'b1};
    qv[8]  = '{1'b1, 1'b0, 3'd2, 1'b0, 1'b1};
    qv[9]  = '{1'b1, 1'b0, 3'd3, 1'b0, 1'b1};
    qv[10] = '{1'b1, 1'b0, 3'd4, 1'b0, 1'b1};
    qv[11] = '{1'b1, 1'b0, 3'd4, 1'b1, 1'b1};
    qv[12] = '{1'b1, 1'b1, 3'd4, 1'b1, 1'b1};
    qv[13] = '{1'b0, 1'b1, 3'd3, 1'b1, 1'b1};
    qv[14] = '{1'b1, 1'b1, 3'd3, 1'b1, 1'b1};
    qv[15] = '{1'b0, 1'b1, 3'd2, 1'b1, 1'b1};
    qv[16] = '{1'b0, 1'b0, 3'd2, 1'b1, 1'b1};

    // reset state
    repeat (2) tick();
    chk("rst_outputs", {sts_pend_cnt, sts_q_ovf, sts_wdt_to, irq, cam_if.cam_rx_en,
                        cam_if.cam_rx_mode, cam_if.cam_rx_start}, 32'd0);
    chk("rst_counts", {sts_frm_cnt, sts_err_cnt}, 32'd0);
    rst_n = 1'b1;
    tick();

    // single-shot queue vectors
    csr_rx_en = 1'b1; csr_rx_mode = 2'd1;
    repeat (2) tick();
    chk("single_en", {cam_if.cam_rx_en, cam_if.cam_rx_mode}, {29'd0, 1'b1, 2'd1});
    for (int i = 0; i <= 16; i++) begin
      csr_start_wr = qv[i].wr;
      cam_if.cam_rx_start_qed = qv[i].qed;
      tick();
      csr_start_wr = 1'b0;
      cam_if.cam_rx_start_qed = 1'b0;
      chk($sformatf("qv%0d_pend", i), sts_pend_cnt, qv[i].pend);
      chk($sformatf("qv%0d_ovf", i), sts_q_ovf, qv[i].ovf);
      chk($sformatf("qv%0d_start", i), cam_if.cam_rx_start, qv[i].start);
    end

    // disable with 2 pending
    csr_rx_en = 1'b0;
    tick();
    chk("dis_pend", sts_pend_cnt, 32'd0);
    chk("dis_start", cam_if.cam_rx_start, 32'd0);
    chk("dis_en", cam_if.cam_rx_en, 32'd0);
    chk("dis_ovf_sticky", sts_q_ovf, 32'd1);
    csr_sts_clr = 1'b1;
    tick();
    csr_sts_clr = 1'b0;
    chk("clr_ovf", sts_q_ovf, 32'd0);

    // reserved mode drives sleep
    csr_rx_en = 1'b1; csr_rx_mode = 2'd3;
    tick();
    chk("rsvd_mode", {cam_if.cam_rx_en, cam_if.cam_rx_mode, cam_if.cam_rx_start}, {28'd0, 1'b1, 2'd0, 1'b0});

    // stream with skip=2
    csr_rx_mode = 2'd2; csr_frm_skip = 4'd2; csr_irq_msk = 3'b001;
    repeat (2) tick();
    chk("stream_start", {cam_if.cam_rx_mode, cam_if.cam_rx_start}, {29'd0, 2'd2, 1'b1});
    cam_if.cam_frm_done = 1'b1;
    tick();
    cam_if.cam_frm_done = 1'b0;
    chk("skip_start_drop", cam_if.cam_rx_start, 32'd0);
    chk("done_irq", irq, 32'd1);
    chk("done_frm_cnt", sts_frm_cnt, 32'd1);
    tick();
    chk("irq_one_cycle", irq, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("skip_hold0", cam_if.cam_rx_start, 32'd0);
    end
    dvp_vsync_pls = 1'b1;
    tick();
    dvp_vsync_pls = 1'b0;
    chk("skip_vs1", cam_if.cam_rx_start, 32'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("skip_hold1", cam_if.cam_rx_start, 32'd0);
    end
    dvp_vsync_pls = 1'b1;
    tick();
    dvp_vsync_pls = 1'b0;
    chk("skip_vs2", cam_if.cam_rx_start, 32'd1);

    // skip=0: start never drops
    csr_frm_skip = 4'd0;
    cam_if.cam_frm_done = 1'b1;
    tick();
    cam_if.cam_frm_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      dvp_vsync_pls = (i == 1);
      chk("noskip_start", cam_if.cam_rx_start, 32'd1);
      tick();
    end
    dvp_vsync_pls = 1'b0;
    chk("frm_cnt2", sts_frm_cnt, 32'd2);

    // watchdog: limit 100, state held in ALIGN
    csr_irq_msk = 3'b100; csr_wdt_limit = 24'd100; cam_if.cam_rx_state = 3'd2;
    repeat (100) tick();
    chk("wdt_not_yet", {sts_wdt_to, irq}, 32'd0);
    tick();
    chk("wdt_to", sts_wdt_to, 32'd1);
    chk("wdt_irq", irq, 32'd1);
    chk("wdt_start_off", cam_if.cam_rx_start, 32'd0);
    cam_if.cam_rx_state = 3'd1; csr_wdt_limit = 24'd0;
    tick();
    chk("wdt_irq_pulse", irq, 32'd0);
    chk("wdt_sticky", sts_wdt_to, 32'd1);

    // clear coincident with frame done
    cam_if.cam_frm_done = 1'b1; csr_sts_clr = 1'b1;
    tick();
    cam_if.cam_frm_done = 1'b0; csr_sts_clr = 1'b0;
    chk("clr_vs_done", sts_frm_cnt, 32'd0);
    chk("clr_wdt_to", sts_wdt_to, 32'd0);

    // counter wrap 0xFFFF -> 0
    csr_irq_msk = 3'b000;
    cam_if.cam_frm_done = 1'b1; cam_if.cam_frm_err = 1'b1;
    repeat (65535) tick();
    chk("frm_ffff", sts_frm_cnt, 32'hFFFF);
    chk("err_ffff", sts_err_cnt, 32'hFFFF);
    tick();
    cam_if.cam_frm_done = 1'b0; cam_if.cam_frm_err = 1'b0;
    chk("frm_wrap", sts_frm_cnt, 32'd0);
    chk("err_wrap", sts_err_cnt, 32'd0);

    // randomized single-shot traffic against the model
    csr_rx_mode = 2'd1; csr_sts_clr = 1'b1;
    tick();
    csr_sts_clr = 1'b0;
    repeat (2) tick();
    m_pend = 0; m_ovf = 1'b0; m_frm = 16'd0; m_err = 16'd0;
    for (int i = 0; i < 400; i++) begin
      csr_start_wr            = ($urandom_range(0, 2) == 0);
      cam_if.cam_rx_start_qed = ($urandom_range(0, 2) == 0);
      cam_if.cam_frm_done     = ($urandom_range(0, 7) == 0);
      cam_if.cam_frm_err      = ($urandom_range(0, 7) == 0);
      csr_sts_clr             = ($urandom_range(0, 15) == 0);
      csr_irq_msk             = 3'($urandom_range(0, 7));
      if (csr_start_wr && m_pend == 4) m_ovf = 1'b1;
      if (csr_start_wr && !cam_if.cam_rx_start_qed && m_pend < 4) m_pend = m_pend + 1;
      else if (!csr_start_wr && cam_if.cam_rx_start_qed && m_pend > 0) m_pend = m_pend - 1;
      if (csr_sts_clr) begin
        m_ovf = 1'b0; m_frm = 16'd0; m_err = 16'd0;
      end else begin
        if (cam_if.cam_frm_done) m_frm = m_frm + 16'd1;
        if (cam_if.cam_frm_err)  m_err = m_err + 16'd1;
      end
      m_irq = (cam_if.cam_frm_done & csr_irq_msk[0]) | (cam_if.cam_frm_err & csr_irq_msk[1]);
      tick();
      chk("rnd_pend", sts_pend_cnt, m_pend);
      chk("rnd_ovf", sts_q_ovf, m_ovf);
      chk("rnd_cnts", {sts_frm_cnt, sts_err_cnt}, {m_frm, m_err});
      chk("rnd_irq", irq, m_irq);
      chk("rnd_start", cam_if.cam_rx_start, (m_pend != 0));
    end
    csr_start_wr = 1'b0; cam_if.cam_rx_start_qed = 1'b0; csr_sts_clr = 1'b0;
    cam_if.cam_frm_done = 1'b0; cam_if.cam_frm_err = 1'b0;

    // reset while in SKIP
    csr_rx_mode = 2'd2; csr_frm_skip = 4'd3;
    repeat (3) tick();
    cam_if.cam_frm_done = 1'b1;
    tick();
    cam_if.cam_frm_done = 1'b0;
    chk("pre_rst_skip", cam_if.cam_rx_start, 32'd0);
    dvp_vsync_pls = 1'b1;
    tick();
    dvp_vsync_pls = 1'b0;
    chk("pre_rst_frm", (sts_frm_cnt != 16'd0), 32'd1);
    rst_n = 1'b0;
    #2;
    chk("midskip_rst_outputs", {sts_pend_cnt, sts_q_ovf, sts_wdt_to, irq, cam_if.cam_rx_en,
                                cam_if.cam_rx_mode, cam_if.cam_rx_start}, 32'd0);
    chk("midskip_rst_counts", {sts_frm_cnt, sts_err_cnt}, 32'd0);
    tick();
    rst_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
